// File: rtl/fetch_decode_pkg.sv
// Shared CPU definitions: opcodes, halt pattern, instruction field positions, FSM states.
// Used by fetch_decode, instr_decode and the datapath bench.
package cpu_defs;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_SYS  = 2'b11;

    localparam logic [5:0] SYS_HALT = 6'b111111;

    localparam int unsigned OP_HI  = 7;
    localparam int unsigned OP_LO  = 6;
    localparam int unsigned W_HI   = 5;
    localparam int unsigned W_LO   = 4;
    localparam int unsigned A_HI   = 3;
    localparam int unsigned A_LO   = 2;
    localparam int unsigned B_HI   = 1;
    localparam int unsigned B_LO   = 0;
    localparam int unsigned IMM_HI = 3;
    localparam int unsigned IMM_LO = 0;
    localparam int unsigned SYS_HI = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_HALT
    } state_t;

endpackage

// File: rtl/fetch_decode_instr_decode.sv
// Combinational instruction decoder: instruction register in, datapath control fields out.
module instr_decode
    import cpu_defs::*;
(
    input  logic [7:0] ir,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic [1:0] sel_w,
    output logic [3:0] imm,
    output logic       sel_data,
    output logic       alu_op,
    output logic       write_en,
    output logic       is_halt
);

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_w    = '0;
        imm      = '0;
        sel_data = 1'b0;
        alu_op   = 1'b0;
        write_en = 1'b0;
        is_halt  = 1'b0;
        case (ir[OP_HI:OP_LO])
            OP_PUSH: begin
                sel_w    = ir[W_HI:W_LO];
                imm      = ir[IMM_HI:IMM_LO];
                sel_data = 1'b1;
                write_en = 1'b1;
            end
            OP_ADD, OP_NAND: begin
                sel_a    = ir[A_HI:A_LO];
                sel_b    = ir[B_HI:B_LO];
                sel_w    = ir[W_HI:W_LO];
                alu_op   = (ir[OP_HI:OP_LO] == OP_NAND);
                write_en = 1'b1;
            end
            default: is_halt = (ir[SYS_HI:0] == SYS_HALT);
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Multi-cycle fetch/decode controller: FETCH -> LOAD -> EXEC per instruction,
// synchronous ROM, controls driven only during EXEC.
module fetch_decode
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [7:0]        instr_data,
    output logic [1:0]        SEL_A,
    output logic [1:0]        SEL_B,
    output logic [1:0]        SEL_W,
    output logic [3:0]        IMM,
    output logic              sel_data,
    output logic              alu_op,
    output logic              write_en,
    output logic              halted
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        ir;

    logic [1:0] dec_sel_a, dec_sel_b, dec_sel_w;
    logic [3:0] dec_imm;
    logic       dec_sel_data, dec_alu_op, dec_write_en, dec_is_halt;

    instr_decode u_decode (
        .ir       (ir),
        .sel_a    (dec_sel_a),
        .sel_b    (dec_sel_b),
        .sel_w    (dec_sel_w),
        .imm      (dec_imm),
        .sel_data (dec_sel_data),
        .alu_op   (dec_alu_op),
        .write_en (dec_write_en),
        .is_halt  (dec_is_halt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE:  if (run) state <= S_FETCH;
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    ir    <= instr_data;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (dec_is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign instr_addr = pc;

    // Decoded fields only reach the datapath in EXEC; rst_n gates the write
    // so a reset landing on EXEC cannot commit a register write.
    always_comb begin
        SEL_A    = '0;
        SEL_B    = '0;
        SEL_W    = '0;
        IMM      = '0;
        sel_data = 1'b0;
        alu_op   = 1'b0;
        write_en = 1'b0;
        if (state == S_EXEC) begin
            SEL_A    = dec_sel_a;
            SEL_B    = dec_sel_b;
            SEL_W    = dec_sel_w;
            IMM      = dec_imm;
            sel_data = dec_sel_data;
            alu_op   = dec_alu_op;
            write_en = dec_write_en & rst_n;
        end
    end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed self-checking bench for fetch_decode with a synchronous ROM model.
module tb_fetch_decode;

    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run;
    logic [ADDR_W-1:0] instr_addr;
    logic [7:0]        instr_data;
    logic [1:0]        SEL_A, SEL_B, SEL_W;
    logic [3:0]        IMM;
    logic              sel_data, alu_op, write_en, halted;

    logic [7:0] rom [16];

    int errors = 0;
    int checks = 0;

    fetch_decode #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .instr_addr (instr_addr),
        .instr_data (instr_data),
        .SEL_A      (SEL_A),
        .SEL_B      (SEL_B),
        .SEL_W      (SEL_W),
        .IMM        (IMM),
        .sel_data   (sel_data),
        .alu_op     (alu_op),
        .write_en   (write_en),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr_data <= rom[instr_addr];

    // {SEL_A, SEL_B, SEL_W, IMM, sel_data, alu_op, write_en}
    function automatic logic [12:0] mk(input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] w, input logic [3:0] imm,
                                       input logic sd, input logic op, input logic we);
        return {a, b, w, imm, sd, op, we};
    endfunction

    wire [12:0] ctrl = {SEL_A, SEL_B, SEL_W, IMM, sel_data, alu_op, write_en};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_noop();
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    endtask

    // Reset for two edges; leaves the bench at a negedge with rst_n released.
    task automatic do_reset(input logic run_val);
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run   = run_val;
    endtask

    // Advance through FETCH and LOAD (write_en must stay low) and stop in EXEC.
    task automatic to_exec(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, "_pre_we"}, 32'(write_en), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        fill_noop();

        // Reset state, held in IDLE with run low
        do_reset(1'b0);
        check("rst_addr", 32'(instr_addr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        @(negedge clk);
        check("idle_ctrl", 32'(ctrl), 32'd0);
        check("idle_addr", 32'(instr_addr), 32'd0);

        // push r0 #0: write only in third cycle
        rom[0] = 8'h00;
        run = 1'b1;
        to_exec("push0");
        check("push0_ctrl", 32'(ctrl), 32'(mk(2'd0, 2'd0, 2'd0, 4'h0, 1'b1, 1'b0, 1'b1)));
        @(negedge clk);
        check("push0_after_we", 32'(write_en), 32'd0);

        // Program of push/push/add/nand; run dropped after leaving IDLE
        fill_noop();
        rom[0] = 8'h1F; rom[1] = 8'h22; rom[2] = 8'h64; rom[3] = 8'h89;
        do_reset(1'b1);
        @(negedge clk);
        run = 1'b0;
        check("prog_fetch_ctrl", 32'(ctrl), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("i0_ctrl", 32'(ctrl), 32'(mk(2'd0, 2'd0, 2'd1, 4'hF, 1'b1, 1'b0, 1'b1)));
        to_exec("i1");
        check("i1_ctrl", 32'(ctrl), 32'(mk(2'd0, 2'd0, 2'd2, 4'h2, 1'b1, 1'b0, 1'b1)));
        to_exec("i2");
        check("i2_ctrl", 32'(ctrl), 32'(mk(2'd1, 2'd0, 2'd2, 4'h0, 1'b0, 1'b0, 1'b1)));
        to_exec("i3");
        check("i3_ctrl", 32'(ctrl), 32'(mk(2'd2, 2'd1, 2'd0, 4'h0, 1'b0, 1'b1, 1'b1)));
        @(negedge clk);
        check("pc_after4", 32'(instr_addr), 32'd4);
        check("fetch_ctrl_zero", 32'(ctrl), 32'd0);
        // noop at ROM[4]
        @(negedge clk);
        check("noop_load_we", 32'(write_en), 32'd0);
        @(negedge clk);
        check("noop_exec_ctrl", 32'(ctrl), 32'd0);
        check("noop_exec_addr", 32'(instr_addr), 32'd4);
        @(negedge clk);
        check("noop_pc_next", 32'(instr_addr), 32'd5);

        // Halt at ROM[3] after three noops
        fill_noop();
        rom[3] = 8'hFF;
        do_reset(1'b1);
        for (int k = 0; k < 3; k++) to_exec("pre_halt");
        to_exec("halt");
        check("halt_exec_we", 32'(write_en), 32'd0);
        check("halt_exec_halted", 32'(halted), 32'd0);
        for (int c = 0; c < 20; c++) begin
            run = ~run;
            @(negedge clk);
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_addr", 32'(instr_addr), 32'd3);
            check("halt_we", 32'(write_en), 32'd0);
        end

        // Sixteen noops: PC wraps 15 -> 0 and fetching continues
        fill_noop();
        do_reset(1'b1);
        for (int k = 0; k < 16; k++) to_exec("wrap");
        check("wrap_exec15_addr", 32'(instr_addr), 32'd15);
        @(negedge clk);
        check("wrap_addr0", 32'(instr_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("wrap_addr1", 32'(instr_addr), 32'd1);
        check("wrap_halted", 32'(halted), 32'd0);

        // Reset asserted during EXEC of an add
        fill_noop();
        rom[0] = 8'h64;
        do_reset(1'b1);
        to_exec("rst_add");
        check("rst_add_we_before", 32'(write_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_add_we_forced", 32'(write_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b0;
        check("rst_add_addr", 32'(instr_addr), 32'd0);
        check("rst_add_ctrl", 32'(ctrl), 32'd0);
        @(negedge clk);
        check("rst_add_idle_addr", 32'(instr_addr), 32'd0);
        check("rst_add_idle_ctrl", 32'(ctrl), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
